systolic_feeder: RTL and testbench

- Sequencer downstream of the 4x4 operand memory: drives its per-line read enables and element selects, then registers the returned words into a diagonally skewed stream for a 4x4 systolic array.
- Line i starts i cycles after line 0, so each array edge receives one element per line per cycle in wavefront order.
- One start pulse streams the whole 4x4 tile (16 words) in 7 issue cycles.

---
 rtl/systolic_feeder.sv | 120 ++++++++++++
 tb/tb_systolic_feeder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Read sequencer and diagonal skew register stage between the 4x4 operand memory and the systolic array.
// Optional abort input is built when FEEDER_ABORT_EN is defined.
`timescale 1ns/1ps
module systolic_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int DIM        = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
`ifdef FEEDER_ABORT_EN
  input  logic                    abort,
`endif
  input  logic [4*DATA_WIDTH-1:0] mem_data_in,
  output logic [3:0]              rd_en,
  output logic [7:0]              rd_elem,
  output logic [4*DATA_WIDTH-1:0] a_out,
  output logic [3:0]              a_valid,
  output logic                    busy,
  output logic                    done
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | issuing reads, step 0..6 walks the skewed wavefront
  // DRAIN | last skewed word on a_out, done pulses
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  state;
  logic [2:0]              step;
  logic                    kill;
  logic [4*DATA_WIDTH-1:0] a_nxt;

`ifdef FEEDER_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  // Line i trails line 0 by i steps, so its element index is step - i.
  always_comb begin
    rd_en   = '0;
    rd_elem = '0;
    if (state == RUN) begin
      for (int i = 0; i < DIM; i++) begin
        if (step >= 3'(i) && step <= 3'(i + 3)) begin
          rd_en[i]         = 1'b1;
          rd_elem[2*i +: 2] = 2'(step - 3'(i));
        end
      end
    end
  end

  always_comb begin
    a_nxt = '0;
    for (int i = 0; i < DIM; i++) begin
      if (rd_en[i]) a_nxt[DATA_WIDTH*i +: DATA_WIDTH] = mem_data_in[DATA_WIDTH*i +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      step  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (kill) begin
      state <= IDLE;
      step  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          step <= '0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (step == 3'd6) begin
            state <= DRAIN;
            done  <= 1'b1;
          end else begin
            step <= step + 3'd1;
          end
        end
        DRAIN: begin
          state <= IDLE;
          step  <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          step  <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Disabled lines are zeroed so stale memory data never reaches the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid <= '0;
      a_out   <= '0;
    end else if (kill) begin
      a_valid <= '0;
      a_out   <= '0;
    end else begin
      a_valid <= rd_en;
      a_out   <= a_nxt;
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized bench for systolic_feeder: a tile-position counter predicts every output from the issue/skew rules.
`timescale 1ns/1ps
module tb_systolic_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
`ifdef FEEDER_ABORT_EN
  logic        abort = 1'b0;
`endif
  logic [31:0] mem_data_in;
  logic [3:0]  rd_en;
  logic [7:0]  rd_elem;
  logic [31:0] a_out;
  logic [3:0]  a_valid;
  logic        busy;
  logic        done;

  logic [7:0]  mem [4][4];
  int          ph = 0;
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;

  systolic_feeder #(.DATA_WIDTH(8), .DIM(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
`ifdef FEEDER_ABORT_EN
    .abort(abort),
`endif
    .mem_data_in(mem_data_in),
    .rd_en(rd_en),
    .rd_elem(rd_elem),
    .a_out(a_out),
    .a_valid(a_valid),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // Combinational memory; disabled lines return 0xFF to expose leakage.
  always_comb begin
    mem_data_in = '0;
    for (int i = 0; i < 4; i++)
      mem_data_in[8*i +: 8] = rd_en[i] ? mem[i][rd_elem[2*i +: 2]] : 8'hFF;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (t=%0t ph=%0d)", tag, got, exp, $time, ph);
    end
  endtask

  // ph = cycles since the start edge (1..8 active, 0 idle).
  task automatic check_outputs();
    logic [3:0]  e_en, e_val;
    logic [7:0]  e_elem;
    logic [31:0] e_out;
    int k;
    e_en = '0; e_val = '0; e_elem = '0; e_out = '0;
    for (int i = 0; i < 4; i++) begin
      k = ph - 1 - i;
      if (ph >= 1 && k >= 0 && k <= 3) begin
        e_en[i] = 1'b1;
        e_elem[2*i +: 2] = 2'(k);
      end
      k = ph - 2 - i;
      if (ph >= 1 && k >= 0 && k <= 3) begin
        e_val[i] = 1'b1;
        e_out[8*i +: 8] = mem[i][k];
      end
    end
    chk("rd_en", 64'(rd_en), 64'(e_en));
    chk("rd_elem", 64'(rd_elem), 64'(e_elem));
    chk("a_valid", 64'(a_valid), 64'(e_val));
    chk("a_out", 64'(a_out), 64'(e_out));
    chk("busy", 64'(busy), 64'(ph >= 1 && ph <= 8));
    chk("done", 64'(done), 64'(ph == 8));
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
`ifdef FEEDER_ABORT_EN
      if (abort) ph = 0; else
`endif
      if (ph == 0) begin
        if (start) ph = 1;
      end else if (ph == 8) ph = 0;
      else ph = ph + 1;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        mem[i][j] = 8'($urandom);
  endtask

  task automatic run_tile();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        mem[i][j] = 8'(16*i + j);
    #12;
    check_outputs();
    chk("reset_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick();

    // directed tile with mem[i][j] = 16*i+j
    done_cnt = 0;
    run_tile();
    chk("single_done_cnt", 64'(done_cnt), 64'd1);

    // start held high: tiles at C1 and C10, DRAIN of second in C17
    rand_mem();
    done_cnt = 0;
    start = 1'b1;
    repeat (18) tick();
    start = 1'b0;
    repeat (10) tick();
    chk("held_done_cnt", 64'(done_cnt), 64'd2);

    // start re-pulsed inside the stream
    rand_mem();
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    chk("repulse_done_cnt", 64'(done_cnt), 64'd1);

    // async reset in C5
    rand_mem();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    ph = 0;
    #1;
    check_outputs();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    rand_mem();
    done_cnt = 0;
    run_tile();
    chk("post_reset_done_cnt", 64'(done_cnt), 64'd1);

`ifdef FEEDER_ABORT_EN
    rand_mem();
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (4) tick();
    chk("abort_done_cnt", 64'(done_cnt), 64'd0);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_blocks_start", 64'(busy), 64'd0);
    rand_mem();
    run_tile();
`endif

    // random start pulses; memory changes only while idle
    for (int c = 0; c < 400; c++) begin
      if (ph == 0 && !start) rand_mem();
      start = ($urandom_range(0, 3) == 0);
      tick();
    end
    start = 1'b0;
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
